// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, 1-cycle imem reads, small output FIFO, {pc+4,instr} toward IF/ID.
// Latency: request in cycle N -> valid_o in cycle N+2; 1 instr/cycle sustained with ready_i high.
// Backpressure: ready_i low holds the head stable; requests stop once FIFO + in-flight reach FIFO_DEPTH.
//
// Ports:
//   clk_i, rst_i (async, active low)
//   imem_req_o / imem_addr_o / imem_rdata_i : synchronous instruction memory, data 1 cycle after req
//   redirect_i / redirect_pc_i              : flush and refetch from a new PC (highest priority)
//   valid_o / ready_i / pc_o / instr_o      : output handshake; pc_o is the instruction address + 4
//   perf_stall_cnt_o / perf_flush_cnt_o     : performance counters
//
// Optional feature: define FETCH_PERF_EN to build the stall/flush counters;
// without it both counter ports are tied to zero.

// Generic synchronous FIFO with flush. Head data is combinational from storage.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller must never push when full.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
);

    localparam int          CW         = $clog2(FIFO_DEPTH + 1);
    // One extra bit so fifo_count + inflight never overflows.
    localparam int          OW         = CW + 1;
    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

    logic [31:0]   pc_q;
    logic [31:0]   req_addr_q;
    logic          inflight_q;
    logic          kill_q;

    logic [CW-1:0] fifo_count;
    fetch_ent_t    push_ent;
    fetch_ent_t    head_ent;
    logic          push;
    logic          pop;
    logic          req;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_after_pop;
    logic          unused_pc_bits;

    // The low address bits of a redirect target are meaningless for word fetch.
    assign unused_pc_bits = ^redirect_pc_i[1:0];

    assign pop           = valid_o & ready_i;

    // A slot is reserved at request time, so an in-flight word always has room.
    // Counting the same-cycle pop lets the stage stream at full rate with only
    // two entries.
    assign occ           = OW'(fifo_count) + OW'(inflight_q);
    assign occ_after_pop = occ - OW'(pop);

    // rst_i gates the request combinationally so it drops the instant reset is
    // asserted, not at the next edge.
    assign req           = rst_i & ~redirect_i & (occ_after_pop < OW'(FIFO_DEPTH));

    // A response arriving in a redirect cycle belongs to the old path. kill_q
    // covers a response landing the cycle after a redirect.
    assign push          = inflight_q & ~kill_q & ~redirect_i;

    assign push_ent.pc    = req_addr_q + 32'd4;
    assign push_ent.instr = imem_rdata_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q       <= RESET_PC_W;
            req_addr_q <= 32'h0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            inflight_q <= req;
            kill_q     <= redirect_i;
            if (redirect_i) begin
                pc_q <= {redirect_pc_i[31:2], 2'b00};
            end else if (req) begin
                // Natural 32-bit wrap: FFFF_FFFC + 4 = 0.
                pc_q       <= pc_q + 32'd4;
                req_addr_q <= pc_q;
            end
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .flush    (redirect_i),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .count    (fifo_count)
    );

    assign imem_req_o  = req;
    assign imem_addr_o = pc_q;

    // The head storage is stale when the FIFO is empty. Mask it so IF/ID sees a
    // clean NOP with pc 0.
    assign valid_o     = (fifo_count != '0);
    assign pc_o        = valid_o ? head_ent.pc    : 32'h0;
    assign instr_o     = valid_o ? head_ent.instr : 32'h0;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (valid_o && !ready_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_i) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`else
    assign perf_stall_cnt_o = 32'h0;
    assign perf_flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

`ifdef FETCH_PERF_EN
    localparam logic [31:0] EXP_STALL  = 32'd5;
    localparam logic [31:0] EXP_FLUSH1 = 32'd1;
    localparam logic [31:0] EXP_FLUSH3 = 32'd3;
`else
    localparam logic [31:0] EXP_STALL  = 32'd0;
    localparam logic [31:0] EXP_FLUSH1 = 32'd0;
    localparam logic [31:0] EXP_FLUSH3 = 32'd0;
`endif

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    logic        hi_ready;
    logic        hi_redirect;
    logic [31:0] hi_redirect_pc;
    logic        hi_req;
    logic [31:0] hi_addr;
    logic [31:0] hi_rdata;
    logic        hi_valid;
    logic [31:0] hi_pc;
    logic [31:0] hi_instr;
    logic [31:0] hi_stall_cnt;
    logic [31:0] hi_flush_cnt;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memv(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous instruction memory models: data one cycle after the request.
    always @(posedge clk) begin
        if (req)    rdata    <= memv(addr);
        if (hi_req) hi_rdata <= memv(hi_addr);
    end

    if_fetch_unit u_dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .imem_req_o       (req),
        .imem_addr_o      (addr),
        .imem_rdata_i     (rdata),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .valid_o          (valid),
        .ready_i          (ready),
        .pc_o             (pc),
        .instr_o          (instr),
        .perf_stall_cnt_o (stall_cnt),
        .perf_flush_cnt_o (flush_cnt)
    );

    if_fetch_unit #(
        .RESET_PC   (32'hFFFF_FFF8),
        .FIFO_DEPTH (3)
    ) u_dut_hi (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .imem_req_o       (hi_req),
        .imem_addr_o      (hi_addr),
        .imem_rdata_i     (hi_rdata),
        .redirect_i       (hi_redirect),
        .redirect_pc_i    (hi_redirect_pc),
        .valid_o          (hi_valid),
        .ready_i          (hi_ready),
        .pc_o             (hi_pc),
        .instr_o          (hi_instr),
        .perf_stall_cnt_o (hi_stall_cnt),
        .perf_flush_cnt_o (hi_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        ready          = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        hi_ready       = 1'b1;
        hi_redirect    = 1'b0;
        hi_redirect_pc = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_req",   {31'h0, req},   32'h0);
        chk("rst_pc",    pc,             32'h0);
        chk("rst_instr", instr,          32'h0);
        chk("rst_stall", stall_cnt,      32'h0);
        chk("rst_flush", flush_cnt,      32'h0);
        chk("rst_hireq", {31'h0, hi_req}, 32'h0);

        // Streaming from reset, ready held high (both instances)
        rst_n = 1'b1;
        #1;
        chk("t1_req0",   {31'h0, req},   32'h1);
        chk("t1_addr0",  addr,           32'h0);
        chk("t1_val0",   {31'h0, valid}, 32'h0);
        chk("t5_addr0",  hi_addr,        32'hFFFF_FFF8);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t1_addr", addr, 32'(4 * (k + 1)));
            chk("t1_req",  {31'h0, req}, 32'h1);
            chk("t5_addr", hi_addr, 32'hFFFF_FFF8 + 32'(4 * (k + 1)));
            if (k == 0) begin
                chk("t1_val_lat", {31'h0, valid}, 32'h0);
            end else begin
                chk("t1_valid", {31'h0, valid}, 32'h1);
                chk("t1_pc",    pc,    32'(4 * k));
                chk("t1_instr", instr, memv(32'(4 * k - 4)));
                chk("t5_pc",    hi_pc, 32'hFFFF_FFF8 + 32'(4 * k));
                chk("t5_instr", hi_instr, memv(32'hFFFF_FFF4 + 32'(4 * k)));
            end
        end

        // Stall for 5 cycles after the first valid
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t2_first_pc", pc, 32'h4);
        ready = 1'b0;
        #1;
        chk("t2_req_drop", {31'h0, req}, 32'h0);
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("t2_hold_valid", {31'h0, valid}, 32'h1);
            chk("t2_hold_pc",    pc,    32'h4);
            chk("t2_hold_instr", instr, memv(32'h0));
            chk("t2_hold_req",   {31'h0, req}, 32'h0);
        end
        ready = 1'b1;
        #1;
        chk("t2_resume_req",  {31'h0, req}, 32'h1);
        chk("t2_resume_addr", addr, 32'h8);
        tick();
        chk("t2_pc8",     pc,    32'h8);
        chk("t2_instr8",  instr, memv(32'h4));
        chk("t6_stall",   stall_cnt, EXP_STALL);
        tick();
        chk("t2_pc12",    pc,    32'hC);
        tick();
        chk("t2_pc16",    pc,    32'h10);
        chk("t2_instr16", instr, memv(32'hC));

        // Redirect while one entry is buffered and one word is in flight
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        chk("t3_req_blk", {31'h0, req},   32'h0);
        chk("t3_popping", {31'h0, valid}, 32'h1);
        tick();
        redirect = 1'b0;
        #1;
        chk("t3_valid0", {31'h0, valid}, 32'h0);
        chk("t3_addr",   addr,  32'h100);
        chk("t3_req",    {31'h0, req}, 32'h1);
        chk("t3_pc0",    pc,    32'h0);
        chk("t3_instr0", instr, 32'h0);
        chk("t6_flush",  flush_cnt, EXP_FLUSH1);
        tick();
        chk("t3_nostale", {31'h0, valid}, 32'h0);
        tick();
        chk("t3_pc",     pc,    32'h104);
        chk("t3_instr",  instr, memv(32'h100));
        chk("t6_stall2", stall_cnt, EXP_STALL);

        // Back-to-back redirects: the last one wins
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        #1;
        chk("t3b_req",   {31'h0, req},   32'h0);
        chk("t3b_valid", {31'h0, valid}, 32'h0);
        tick();
        redirect = 1'b0;
        #1;
        chk("t3b_addr",  addr, 32'h300);
        tick();
        tick();
        chk("t3b_pc",    pc,    32'h304);
        chk("t3b_instr", instr, memv(32'h300));
        chk("t3b_flush", flush_cnt, EXP_FLUSH3);
        tick();
        chk("t3b_pc2",   pc,    32'h308);

        // Asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        chk("t4_valid", {31'h0, valid}, 32'h0);
        chk("t4_req",   {31'h0, req},   32'h0);
        chk("t4_pc",    pc,             32'h0);
        chk("t4_instr", instr,          32'h0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("t4_addr",  addr, 32'h0);
        chk("t4_req1",  {31'h0, req}, 32'h1);
        tick();
        tick();
        chk("t4_pc4",    pc,    32'h4);
        chk("t4_instr4", instr, memv(32'h0));
        chk("t4_stall0", stall_cnt, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
